// File: rtl/jtag_tap_responder_pkg.sv
// Shared types and constants for the JTAG TAP responder: the 16-state TAP
// encoding, the data-register selector, default opcodes and the TMS
// next-state table.
package jtag_pkg_hdl;

    // IEEE 1149.1 state encodings; Test-Logic-Reset is all ones
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    // Which data register sits between tdi and tdo
    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_t;

    localparam int          DEFAULT_IR_WIDTH     = 4;
    localparam int          DEFAULT_DR_WIDTH     = 32;
    localparam int          DEFAULT_SYNC_STAGES  = 2;
    localparam int          IDCODE_WIDTH         = 32;
    localparam logic [31:0] DEFAULT_IDCODE_VALUE = 32'h1234_5001;
    localparam logic [3:0]  DEFAULT_IDCODE_INSTR = 4'b0001;
    localparam logic [3:0]  DEFAULT_USER_INSTR   = 4'b0010;

    // The IR always captures ...0001 so an initiator can find the IR length
    localparam logic [1:0]  IR_CAPTURE_LSBS      = 2'b01;

    function automatic tap_state_t tap_next(input tap_state_t state, input logic tms);
        tap_state_t nxt;
        case (state)
            TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          nxt = TEST_LOGIC_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_responder_if.sv
// JTAG pin bundle between an initiator (master) and the TAP responder (slave).
interface jtag_tap_responder_if;

    logic tck;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;

    modport master (
        output tck,
        output tms,
        output tdi,
        input  tdo,
        input  tdo_en
    );

    modport slave (
        input  tck,
        input  tms,
        input  tdi,
        output tdo,
        output tdo_en
    );

endinterface

// File: rtl/jtag_tap_responder_fsm.sv
// TAP controller state machine. Advances one step per synchronised tck
// rising strobe and decodes the states the datapath acts on.
module jtag_tap_fsm
    import jtag_pkg_hdl::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       tck_rise,
    input  logic       tms_s,
    output tap_state_t tap_state,
    output logic       is_tlr,
    output logic       is_capture_ir,
    output logic       is_shift_ir,
    output logic       is_update_ir,
    output logic       is_capture_dr,
    output logic       is_shift_dr,
    output logic       is_update_dr
);

    tap_state_t state;
    tap_state_t state_next;

    // State register; reset parks the controller in Test-Logic-Reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= TEST_LOGIC_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next state: hold between tck edges, follow the TMS table on a rise
    always_comb begin
        state_next = state;
        if (tck_rise) begin
            state_next = tap_next(state, tms_s);
        end
    end

    // State decodes used by the IR/DR datapath and tdo logic
    always_comb begin
        tap_state     = state;
        is_tlr        = (state == TEST_LOGIC_RESET);
        is_capture_ir = (state == CAPTURE_IR);
        is_shift_ir   = (state == SHIFT_IR);
        is_update_ir  = (state == UPDATE_IR);
        is_capture_dr = (state == CAPTURE_DR);
        is_shift_dr   = (state == SHIFT_DR);
        is_update_dr  = (state == UPDATE_DR);
    end

endmodule

// File: rtl/jtag_tap_responder.sv
// JTAG TAP responder: oversamples tck/tms/tdi on the system clock, runs the
// TAP FSM and implements BYPASS, IDCODE and a USER data register with a
// parallel capture/update port into core logic.
module jtag_tap_responder
    import jtag_pkg_hdl::*;
#(
    parameter int                    IR_WIDTH     = DEFAULT_IR_WIDTH,
    parameter int                    DR_WIDTH     = DEFAULT_DR_WIDTH,
    parameter logic [31:0]           IDCODE_VALUE = DEFAULT_IDCODE_VALUE,
    parameter logic [IR_WIDTH-1:0]   IDCODE_INSTR = IR_WIDTH'(DEFAULT_IDCODE_INSTR),
    parameter logic [IR_WIDTH-1:0]   USER_INSTR   = IR_WIDTH'(DEFAULT_USER_INSTR),
    parameter int                    SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic                clock,
    input  logic                reset,
    jtag_tap_responder_if.slave jtag,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_value,
    input  logic [DR_WIDTH-1:0] user_dr_in,
    output logic [DR_WIDTH-1:0] user_dr_out,
    output logic                user_dr_update
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_LSBS);

    logic [SYNC_STAGES-1:0]  tck_sync;
    logic [SYNC_STAGES-1:0]  tms_sync;
    logic [SYNC_STAGES-1:0]  tdi_sync;
    logic                    tck_last;
    logic                    tck_rise;
    logic                    tck_fall;
    logic                    tms_s;
    logic                    tdi_s;

    tap_state_t              fsm_state;
    logic                    is_tlr;
    logic                    is_capture_ir;
    logic                    is_shift_ir;
    logic                    is_update_ir;
    logic                    is_capture_dr;
    logic                    is_shift_dr;
    logic                    is_update_dr;

    logic [IR_WIDTH-1:0]     ir_shift;
    logic [IDCODE_WIDTH-1:0] idcode_shift;
    logic [DR_WIDTH-1:0]     user_shift;
    logic                    bypass_reg;
    dr_sel_t                 dr_sel;
    logic                    dr_lsb;
    logic                    tdo_q;
    logic                    tdo_en_q;

    // Bring the asynchronous JTAG pins into the clock domain; tck gets one
    // extra flop so its edges can be detected on the last synchroniser stage
    always_ff @(posedge clock) begin
        if (reset) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_last <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], jtag.tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], jtag.tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], jtag.tdi};
            tck_last <= tck_sync[SYNC_STAGES-1];
        end
    end

    assign tck_rise = tck_sync[SYNC_STAGES-1] & ~tck_last;
    assign tck_fall = ~tck_sync[SYNC_STAGES-1] & tck_last;
    assign tms_s    = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];

    jtag_tap_fsm u_fsm (
        .clock         (clock),
        .reset         (reset),
        .tck_rise      (tck_rise),
        .tms_s         (tms_s),
        .tap_state     (fsm_state),
        .is_tlr        (is_tlr),
        .is_capture_ir (is_capture_ir),
        .is_shift_ir   (is_shift_ir),
        .is_update_ir  (is_update_ir),
        .is_capture_dr (is_capture_dr),
        .is_shift_dr   (is_shift_dr),
        .is_update_dr  (is_update_dr)
    );

    assign tap_state = fsm_state;

    // Decode the active instruction; anything not IDCODE or USER is bypass
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_value == IDCODE_INSTR) begin
            dr_sel = DR_IDCODE;
        end else if (ir_value == USER_INSTR) begin
            dr_sel = DR_USER;
        end
    end

    // LSB of whichever data register is currently selected
    always_comb begin
        dr_lsb = bypass_reg;
        case (dr_sel)
            DR_IDCODE: dr_lsb = idcode_shift[0];
            DR_USER:   dr_lsb = user_shift[0];
            default:   dr_lsb = bypass_reg;
        endcase
    end

    // Capture and shift on tck rise, keyed on the state being left
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_shift     <= '0;
            idcode_shift <= '0;
            user_shift   <= '0;
            bypass_reg   <= 1'b0;
        end else if (tck_rise) begin
            if (is_capture_ir) begin
                ir_shift <= IR_CAPTURE;
            end else if (is_shift_ir) begin
                ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
            end

            if (is_capture_dr) begin
                case (dr_sel)
                    DR_IDCODE: idcode_shift <= IDCODE_VALUE;
                    DR_USER:   user_shift   <= user_dr_in;
                    default:   bypass_reg   <= 1'b0;
                endcase
            end else if (is_shift_dr) begin
                case (dr_sel)
                    DR_IDCODE: idcode_shift <= {tdi_s, idcode_shift[IDCODE_WIDTH-1:1]};
                    DR_USER:   user_shift   <= {tdi_s, user_shift[DR_WIDTH-1:1]};
                    default:   bypass_reg   <= tdi_s;
                endcase
            end
        end
    end

    // Instruction and USER updates land on the tck fall inside Update-IR/DR;
    // sitting in Test-Logic-Reset forces the instruction back to IDCODE
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_value       <= IDCODE_INSTR;
            user_dr_out    <= '0;
            user_dr_update <= 1'b0;
        end else begin
            user_dr_update <= 1'b0;
            if (is_tlr) begin
                ir_value <= IDCODE_INSTR;
            end else if (tck_fall && is_update_ir) begin
                ir_value <= ir_shift;
            end
            if (tck_fall && is_update_dr && (dr_sel == DR_USER)) begin
                user_dr_out    <= user_shift;
                user_dr_update <= 1'b1;
            end
        end
    end

    // Present the next serial bit on tck fall; tdo is quiet outside shifts
    always_ff @(posedge clock) begin
        if (reset) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else if (tck_fall) begin
            tdo_en_q <= is_shift_ir | is_shift_dr;
            if (is_shift_ir) begin
                tdo_q <= ir_shift[0];
            end else if (is_shift_dr) begin
                tdo_q <= dr_lsb;
            end else begin
                tdo_q <= 1'b0;
            end
        end
    end

    assign jtag.tdo    = tdo_q;
    assign jtag.tdo_en = tdo_en_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for the JTAG TAP responder: drives the pins as a slow
// initiator and compares tdo words and side-band outputs to hand values.
module tb_jtag_tap_responder;

    localparam int HALF = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  tap_state;
    logic [3:0]  ir_value;
    logic [31:0] user_dr_in;
    logic [31:0] user_dr_out;
    logic        user_dr_update;

    int          check_count = 0;
    int          error_count = 0;
    int          pulse_count = 0;

    jtag_tap_responder_if jtag ();

    jtag_tap_responder dut (
        .clock          (clock),
        .reset          (reset),
        .jtag           (jtag.slave),
        .tap_state      (tap_state),
        .ir_value       (ir_value),
        .user_dr_in     (user_dr_in),
        .user_dr_out    (user_dr_out),
        .user_dr_update (user_dr_update)
    );

    // Free-running system clock
    always #5 clock = ~clock;

    // Count one comparison and report it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One full tck cycle with the given tms/tdi, counting update pulses
    task automatic applyStimulus(input logic tms_val, input logic tdi_val);
        jtag.tms = tms_val;
        jtag.tdi = tdi_val;
        repeat (2) @(negedge clock);
        jtag.tck = 1'b1;
        repeat (HALF) begin
            @(negedge clock);
            if (user_dr_update) pulse_count++;
        end
        jtag.tck = 1'b0;
        repeat (HALF) begin
            @(negedge clock);
            if (user_dr_update) pulse_count++;
        end
    endtask

    // From Run-Test/Idle or Test-Logic-Reset into Shift-DR
    task automatic enterShiftDr();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    // From Run-Test/Idle or Test-Logic-Reset into Shift-IR
    task automatic enterShiftIr();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    // Shift nbits LSB first, leaving in Exit1; collects tdo and tdo_en
    task automatic shiftData(input int nbits, input logic [31:0] tdi_word,
                             output logic [31:0] tdo_word, output int en_count);
        tdo_word = '0;
        en_count = 0;
        for (int j = 0; j < nbits; j++) begin
            tdo_word[j] = jtag.tdo;
            if (jtag.tdo_en) en_count++;
            applyStimulus(j == nbits - 1, tdi_word[j]);
        end
    endtask

    // Exit1 -> Update -> Run-Test/Idle
    task automatic updateAndIdle();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    logic [31:0] word;
    int          en_count;

    initial begin
        jtag.tck   = 1'b0;
        jtag.tms   = 1'b1;
        jtag.tdi   = 1'b0;
        user_dr_in = 32'hCAFE_F00D;
        reset      = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] reset state");
        checkOutput("rst_state",  {28'd0, tap_state}, 32'hF);
        checkOutput("rst_ir",     {28'd0, ir_value},  32'h1);
        checkOutput("rst_tdo_en", {31'd0, jtag.tdo_en}, 32'h0);
        checkOutput("rst_tdo",    {31'd0, jtag.tdo},    32'h0);
        checkOutput("rst_udr",    user_dr_out,          32'h0);
        checkOutput("rst_upd",    {31'd0, user_dr_update}, 32'h0);

        $display("[TB] IDCODE read");
        enterShiftDr();
        checkOutput("id_state", {28'd0, tap_state}, 32'h2);
        shiftData(32, 32'h0, word, en_count);
        checkOutput("id_word", word, 32'h1234_5001);
        checkOutput("id_en_count", en_count, 32);
        checkOutput("id_en_exit", {31'd0, jtag.tdo_en}, 32'h0);
        checkOutput("id_tdo_exit", {31'd0, jtag.tdo}, 32'h0);
        updateAndIdle();

        $display("[TB] BYPASS");
        enterShiftIr();
        shiftData(4, 32'hF, word, en_count);
        checkOutput("ir_capture", word, 32'h1);
        checkOutput("ir_en_count", en_count, 4);
        updateAndIdle();
        checkOutput("ir_bypass", {28'd0, ir_value}, 32'hF);
        enterShiftDr();
        shiftData(4, 32'hD, word, en_count);
        checkOutput("bypass_tdo", word, 32'hA);
        updateAndIdle();

        $display("[TB] USER register");
        enterShiftIr();
        shiftData(4, 32'h2, word, en_count);
        updateAndIdle();
        checkOutput("ir_user", {28'd0, ir_value}, 32'h2);
        enterShiftDr();
        shiftData(32, 32'hDEAD_BEEF, word, en_count);
        checkOutput("user_capture", word, 32'hCAFE_F00D);
        checkOutput("user_hold", user_dr_out, 32'h0);
        pulse_count = 0;
        updateAndIdle();
        checkOutput("user_out", user_dr_out, 32'hDEAD_BEEF);
        checkOutput("user_pulse", pulse_count, 1);

        $display("[TB] five TMS=1 to Test-Logic-Reset");
        enterShiftIr();
        shiftData(4, 32'hF, word, en_count);
        updateAndIdle();
        checkOutput("ir_bypass2", {28'd0, ir_value}, 32'hF);
        enterShiftDr();
        pulse_count = 0;
        repeat (5) applyStimulus(1'b1, 1'b0);
        checkOutput("tlr_state", {28'd0, tap_state}, 32'hF);
        checkOutput("tlr_ir", {28'd0, ir_value}, 32'h1);
        checkOutput("tlr_udr", user_dr_out, 32'hDEAD_BEEF);
        checkOutput("tlr_pulse", pulse_count, 0);

        $display("[TB] reset during shift");
        enterShiftDr();
        repeat (9) applyStimulus(1'b0, 1'b0);
        jtag.tck = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("mid_en_before", {31'd0, jtag.tdo_en}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("mid_state", {28'd0, tap_state}, 32'hF);
        checkOutput("mid_tdo", {31'd0, jtag.tdo}, 32'h0);
        checkOutput("mid_tdo_en", {31'd0, jtag.tdo_en}, 32'h0);
        repeat (3) @(negedge clock);
        jtag.tck = 1'b0;
        jtag.tms = 1'b1;
        repeat (6) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        enterShiftDr();
        shiftData(32, 32'h0, word, en_count);
        checkOutput("id_after_reset", word, 32'h1234_5001);
        updateAndIdle();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/jtag_tap_responder.md
Name: jtag_tap_responder

Overview:
Responder (target) end of the jtag bus: a synthesizable IEEE 1149.1-style TAP controller that an initiator BFM drives through tck/tms/tdi and that answers on tdo. It oversamples the JTAG pins on the system clock, runs the 16-state TAP FSM, and supports three instructions: BYPASS, IDCODE and a USER data register. The USER register has a parallel capture/update port into core logic. It serves as the DUT-side counterpart for jtag agent benches and as a reusable debug port.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
DR_WIDTH, 32, USER data register width
IDCODE_VALUE, 32'h1234_5001, captured in IDCODE; bit 0 must be 1
IDCODE_INSTR, 4'b0001, IDCODE opcode; IR reset value
USER_INSTR, 4'b0010, USER opcode
SYNC_STAGES, 2, synchronizer depth on tck/tms/tdi (>=2)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high
tck  input  1  JTAG test clock, asynchronous to clock
tms  input  1  test mode select
tdi  input  1  test data in
tdo  output  1  test data out
tdo_en  output  1  tdo valid (Shift-IR/Shift-DR)
tap_state  output  4  current TAP state (tap_state_t encoding)
ir_value  output  IR_WIDTH  active instruction
user_dr_in  input  DR_WIDTH  value loaded in Capture-DR when USER is active
user_dr_out  output  DR_WIDTH  value latched in Update-DR when USER is active
user_dr_update  output  1  one-clock pulse when user_dr_out is written

Behaviour:
- Reset (sync, high): tap_state=TEST_LOGIC_RESET, ir_value=IDCODE_INSTR, tdo=0, tdo_en=0, user_dr_out=0, user_dr_update=0, shift registers=0, synchronizers=0.
- tck, tms and tdi each pass through SYNC_STAGES flops. tck_rise and tck_fall are single-clock strobes from the last two tck stages. tms/tdi are taken from the stage aligned with the edge-detect stage.
- Latency: a pin tck rising edge acts SYNC_STAGES+1 clocks later. Legal stimulus: tck high and low each >= SYNC_STAGES+2 clocks. Shorter pulses are unsupported and are not flagged.
- On tck_rise: the FSM advances per the standard TMS table. Test-Logic-Reset is reached from any state after 5 consecutive TMS=1.
- Entering TEST_LOGIC_RESET sets ir_value=IDCODE_INSTR. user_dr_out is not changed.
- Capture-IR: ir_shift <= {IR_WIDTH-2 zeros, 2'b01}.
- Shift-IR: each tck_rise shifts right, tdi into the MSB.
- Update-IR: ir_value <= ir_shift.
- Capture-DR by instruction:
  - IDCODE: dr_shift <= IDCODE_VALUE.
  - USER: dr_shift <= user_dr_in.
  - BYPASS (all ones) or any undefined opcode: 1-bit bypass register <= 0.
- Shift-DR: the selected register shifts right, LSB first, tdi into the MSB. Register length is 32 (IDCODE), DR_WIDTH (USER) or 1 (bypass).
- Update-DR with USER active: user_dr_out <= dr_shift; user_dr_update=1 for exactly one clock. Update-DR with any other instruction has no effect.
- On tck_fall:
  - tdo <= LSB of the active shift register (IR in Shift-IR, selected DR in Shift-DR).
  - tdo_en <= 1 in Shift-IR or Shift-DR, else 0.
  - Outside shift states, tdo <= 0.
- The shift-state check uses the state after the preceding rise.
- tck_rise and tck_fall never coincide by construction. Reset has priority over any edge in the same clock.
- Reset asserted mid-shift: the next clock shows all reset values and the partial shift is discarded.

Decomposition:
- jtag_pkg_hdl holds:
  - tap_state_t: 4-bit enum of the 16 states with IEEE encodings, TEST_LOGIC_RESET=4'hF.
  - next-state function tap_next(state, tms).
  - default opcode constants and the IR capture pattern.
- Sub-module jtag_tap_fsm: state register and transitions, driven by tck_rise and tms_s.
- Top level contains the synchronizers, IR/DR datapath and tdo logic.

Test Plan:
- Pulse reset -> tap_state=4'hF, ir_value=4'b0001, tdo_en=0 and user_dr_out=0 on the next clock.
- After reset, TMS 0,1,0,0 then 32 shifts with TMS=0..0,1 -> tdo LSB-first reads 0x12345001, tdo_en high for all 32 falls.
- Shift-IR loading 4'b1111 -> tdo shows 1,0,0,0. Then Shift-DR tdi=1,0,1,1 -> tdo=0,1,0,1 (one-bit bypass delay).
- IR=USER_INSTR, user_dr_in=0xCAFEF00D, shift in 0xDEADBEEF -> tdo reads 0xCAFEF00D; after Update-DR, user_dr_out=0xDEADBEEF with a one-clock user_dr_update pulse.
- From Shift-DR, 5 tck cycles with TMS=1 -> tap_state=TEST_LOGIC_RESET, ir_value=IDCODE_INSTR, user_dr_out unchanged.
- Sync reset asserted during the 10th Shift-DR bit -> next clock tap_state=4'hF, tdo=0, tdo_en=0; a fresh IDCODE read returns 0x12345001.
